piped_args_packer: RTL and testbench
====================================

// Module: piped_args_packer
// PURPOSE
//  Producer side of piped_adder: collects N_args signed samples arriving serially on a
//  valid/ready stream and packs them into the parallel args bus (slot i at [(i+1)*W-1:i*W]).
//  Presents each completed frame with a held we/ready handshake toward piped_adder.args_in/we.
//  Double-buffered (fill buffer + output register) so the input sustains one sample/clk.
// PARAMETERS
//  N_args     9   number of slots per frame (1..1024, N_args*arg_width <= 65536)
//  arg_width  4   bits per signed sample
// PORTS
//  clk        in   1              single clock, all logic on posedge
//  reset      in   1              synchronous, active-high
//  din        in   arg_width      signed sample
//  din_valid  in   1              din present
//  din_ready  out  1              packer accepts din this cycle
//  flush      in   1              close partial frame, zero-pad remaining slots
//  args_out   out  N_args*arg_width  packed frame, slot 0 = first accepted sample
//  we         out  1              args_out valid; held until out_ready
//  out_ready  in   1              downstream consumes frame when we&&out_ready
//  overflow   out  1              sticky: din_valid seen while din_ready=0
// BEHAVIOUR
//  Reset: cnt=0, fill_full=0, we=0, args_out=0, overflow=0, din_ready=1 after reset edge;
//   reset mid-frame discards partial and pending frames; no we after reset.
//  Accept = din_valid && din_ready; sample written to fill slot cnt, cnt++.
//  cnt width = CEIL_LOG2(N_args)+1; wraps to 0 when frame closes; never reaches N_args.
//  Frame close: accept with cnt==N_args-1, or flush with (cnt>0 or accept this cycle).
//   Flush+accept same cycle: sample stored first, remaining slots zeroed.
//   flush with cnt==0 and no accept: ignored. N_args==1: every accept closes.
//  Output free = !we || out_ready. On close with output free: frame (incl. closing
//   sample/zero padding) loads args_out, we=1 next cycle (latency 1 clk from last accept).
//  On close with output busy: fill_full=1, din_ready=0; when output frees, transfer
//   fill->args_out, we stays/goes 1 next cycle, fill_full=0, din_ready=1 next cycle.
//  we && out_ready with nothing to load: we=0 next cycle. args_out stable while we=1.
//  din_ready = !fill_full (registered, no comb path from out_ready to din_ready).
//  Unused slots of a fresh frame are cleared on close so no stale data leaks.
//  overflow sets on din_valid && !din_ready; cleared only by reset.
//  States (implicit): FILLING (fill_full=0), HELD (fill_full=1); we independent.
//  No arithmetic; data passed bit-exact, sign untouched.
// STRUCTURE
//  CEIL_LOG2 macro moves to shared include (dsp_defs.vh) used by piped_adder and this.
//  Flat module, no sub-module; generate loop for per-slot write enables.
// TESTING (N_args=9, arg_width=4, out_ready=1 unless stated)
//  1 Stream 1..9 back-to-back -> we one cycle after 9th, args_out=0x987654321, din_ready=1.
//  2 27 samples continuous -> three we frames, no din_ready drop, feeding piped_adder
//    sums equal reference ($random, signed).
//  3 out_ready=0 during 2nd frame -> 2nd frame held in fill, din_ready=0, overflow on
//    extra din_valid; raise out_ready -> 1st frame drains, 2nd appears next cycle.
//  4 Accept -3,5 then flush -> args_out=0x00000005D (slots 2..8 zero), we=1.
//  5 flush with cnt=0 -> no we; flush+accept 7 at cnt=8 -> normal full frame.
//  6 reset asserted at cnt=4 with we=1 -> we=0, din_ready=1, next frame starts at slot 0.

Source files
------------

// File: rtl/piped_args_packer_pkg.sv
// Shared types and helpers for the args packer that feeds piped_adder.
package piped_args_packer_pkg;

  typedef enum logic {
    FILLING = 1'b0,
    HELD    = 1'b1
  } fill_state_t;

  // Smallest r with 2**r >= value; constant-evaluable for parameter sizing.
  function automatic int ceil_log2(input int value);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piped_args_packer.sv
// Packs serially arriving signed samples into a parallel args frame for piped_adder,
// double-buffered so the input stream can sustain one sample per clock.
module piped_args_packer
  import piped_args_packer_pkg::*;
#(
  parameter int N_args    = 9,
  parameter int arg_width = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [arg_width-1:0] din,
  input  logic                        din_valid,
  output logic                        din_ready,
  input  logic                        flush,
  output logic [N_args*arg_width-1:0] args_out,
  output logic                        we,
  input  logic                        out_ready,
  output logic                        overflow
);

  localparam int CW = ceil_log2(N_args) + 1;
  localparam int FW = N_args * arg_width;
  localparam logic [CW-1:0] LAST = CW'(N_args - 1);

  fill_state_t   state;
  fill_state_t   state_next;
  logic [CW-1:0] cnt;
  logic [FW-1:0] fill_buf;
  logic [FW-1:0] frame;
  logic          accept;
  logic          close;
  logic          out_free;

  assign din_ready = (state == FILLING);
  assign accept    = din_valid && din_ready;
  assign close     = din_ready && ((accept && (cnt == LAST)) ||
                                   (flush && ((cnt != '0) || accept)));
  assign out_free  = !we || out_ready;

  // Frame as it stands after this cycle's write: earlier slots kept, the
  // current slot takes din on accept, everything beyond is zero so stale
  // data from a previous frame never leaks into a padded one.
  for (genvar i = 0; i < N_args; i++) begin : g_slot
    localparam logic [CW-1:0] IDX = CW'(i);
    assign frame[i*arg_width +: arg_width] =
      (IDX < cnt)               ? fill_buf[i*arg_width +: arg_width] :
      ((IDX == cnt) && accept)  ? din :
                                  '0;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FILLING;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILLING: if (close && !out_free) state_next = HELD;
      HELD:    if (out_free)           state_next = FILLING;
      default: state_next = FILLING;
    endcase
  end

  // A closed frame goes straight to args_out when the output is free,
  // otherwise it parks in fill_buf until the downstream takes the current one.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      fill_buf <= '0;
      args_out <= '0;
      we       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (din_valid && !din_ready) overflow <= 1'b1;

      if (accept || close) fill_buf <= frame;

      if (close)       cnt <= '0;
      else if (accept) cnt <= cnt + CW'(1);

      if (state == HELD) begin
        if (out_free) begin
          args_out <= fill_buf;
          we       <= 1'b1;
        end
      end else if (close && out_free) begin
        args_out <= frame;
        we       <= 1'b1;
      end else if (we && out_ready) begin
        we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_piped_args_packer.sv
// Directed bench for piped_args_packer with N_args=9, arg_width=4.
module tb_piped_args_packer;

  localparam int N = 9;
  localparam int W = 4;

  logic                clk;
  logic                reset;
  logic signed [W-1:0] din;
  logic                din_valid;
  logic                din_ready;
  logic                flush;
  logic [N*W-1:0]      args_out;
  logic                we;
  logic                out_ready;
  logic                overflow;

  int checks   = 0;
  int failures = 0;

  piped_args_packer #(.N_args(N), .arg_width(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .flush     (flush),
    .args_out  (args_out),
    .we        (we),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then look at the registered result 1 ns after the edge.
  task automatic apply_stimulus(input logic v, input logic [W-1:0] d,
                                input logic f, input logic r);
    din_valid = v;
    din       = d;
    flush     = f;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  logic [N*W-1:0] exp_frame;
  logic [W-1:0]   sample;
  int             drops;
  int             frames_ok;
  int             frames_seen;

  initial begin
    reset     = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #1;
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1);
    check_output("reset_we",        64'(we),        64'd0);
    check_output("reset_din_ready", 64'(din_ready), 64'd1);
    check_output("reset_args_out",  64'(args_out),  64'd0);
    check_output("reset_overflow",  64'(overflow),  64'd0);
    reset = 1'b0;

    // 1: samples 1..9 back-to-back
    for (int k = 1; k <= 9; k++) begin
      check_output("t1_no_early_we", 64'(we), 64'd0);
      apply_stimulus(1, W'(k), 0, 1);
    end
    check_output("t1_we",        64'(we),        64'd1);
    check_output("t1_args_out",  64'(args_out),  64'h987654321);
    check_output("t1_din_ready", 64'(din_ready), 64'd1);
    apply_stimulus(0, 0, 0, 1);
    check_output("t1_we_drop",   64'(we),        64'd0);

    // 2: 27 continuous samples, three frames
    drops       = 0;
    frames_ok   = 0;
    frames_seen = 0;
    exp_frame   = '0;
    for (int j = 0; j < 27; j++) begin
      sample = W'((j * 7 + 3) & 15);
      exp_frame[(j % N)*W +: W] = sample;
      if (!din_ready) drops++;
      apply_stimulus(1, sample, 0, 1);
      if (we) begin
        frames_seen++;
        if (args_out === exp_frame && (j % N) == N - 1) frames_ok++;
      end
    end
    check_output("t2_no_ready_drop", 64'(drops),       64'd0);
    check_output("t2_frames_seen",   64'(frames_seen), 64'd3);
    check_output("t2_frames_ok",     64'(frames_ok),   64'd3);
    check_output("t2_last_frame",    64'(args_out),    64'(exp_frame));
    check_output("t2_overflow",      64'(overflow),    64'd0);
    apply_stimulus(0, 0, 0, 1);

    // 3: output stalled while second frame fills
    for (int k = 0; k < 9; k++) apply_stimulus(1, W'(15 - k), 0, 0);
    check_output("t3_first_we",  64'(we),       64'd1);
    check_output("t3_first_out", 64'(args_out), 64'h789ABCDEF);
    for (int k = 0; k < 9; k++) begin
      sample = W'((2 * (k + 1)) & 15);
      if (k == 8) sample = 4'h1;
      apply_stimulus(1, sample, 0, 0);
    end
    check_output("t3_held_ready", 64'(din_ready), 64'd0);
    check_output("t3_held_we",    64'(we),        64'd1);
    check_output("t3_held_out",   64'(args_out),  64'h789ABCDEF);
    apply_stimulus(1, 4'h3, 0, 0);
    check_output("t3_overflow",   64'(overflow),  64'd1);
    check_output("t3_still_held", 64'(din_ready), 64'd0);
    apply_stimulus(0, 0, 0, 1);
    check_output("t3_second_we",    64'(we),        64'd1);
    check_output("t3_second_out",   64'(args_out),  64'h10ECA8642);
    check_output("t3_ready_back",   64'(din_ready), 64'd1);
    apply_stimulus(0, 0, 0, 1);
    check_output("t3_drained",      64'(we),        64'd0);

    // 4: partial frame -3, 5 then flush
    apply_stimulus(1, 4'hD, 0, 1);
    apply_stimulus(1, 4'h5, 0, 1);
    check_output("t4_no_we_yet", 64'(we), 64'd0);
    apply_stimulus(0, 0, 1, 1);
    check_output("t4_we",       64'(we),       64'd1);
    check_output("t4_args_out", 64'(args_out), 64'h00000005D);
    apply_stimulus(0, 0, 0, 1);

    // 5: empty flush ignored, flush+accept closes a full frame
    apply_stimulus(0, 0, 1, 1);
    check_output("t5_empty_flush", 64'(we), 64'd0);
    for (int k = 1; k <= 8; k++) apply_stimulus(1, W'(k), 0, 1);
    check_output("t5_no_we_at8", 64'(we), 64'd0);
    apply_stimulus(1, 4'h7, 1, 1);
    check_output("t5_we",       64'(we),       64'd1);
    check_output("t5_args_out", 64'(args_out), 64'h787654321);
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(1, 4'h3, 1, 1);
    check_output("t5_single_we",  64'(we),       64'd1);
    check_output("t5_single_out", 64'(args_out), 64'h000000003);
    apply_stimulus(0, 0, 0, 1);

    // 6: reset mid-frame while a frame is presented
    for (int k = 0; k < 9; k++) apply_stimulus(1, 4'hA, 0, 0);
    for (int k = 0; k < 4; k++) apply_stimulus(1, 4'hB, 0, 0);
    check_output("t6_pre_we", 64'(we), 64'd1);
    reset = 1'b1;
    apply_stimulus(0, 0, 0, 0);
    reset = 1'b0;
    check_output("t6_we",        64'(we),        64'd0);
    check_output("t6_din_ready", 64'(din_ready), 64'd1);
    check_output("t6_overflow",  64'(overflow),  64'd0);
    check_output("t6_args_out",  64'(args_out),  64'd0);
    for (int k = 1; k <= 9; k++) apply_stimulus(1, W'(k), 0, 1);
    check_output("t6_restart_we",  64'(we),       64'd1);
    check_output("t6_restart_out", 64'(args_out), 64'h987654321);
    apply_stimulus(0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
